// File: rtl/vrb_arb.sv
// vrb_arb: two-master (LSU, IFU) round-robin arbiter onto one shared slave
// bus, one outstanding transaction at a time.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   i_lsu_vrb_cmd_* / i_ifu_*    master commands (valid/addr/read/wdata/wmask)
//   o_lsu_vrb_rsp_* / o_ifu_*    per-master response (valid/err/rdata)
//   o_vrb_cmd_*                  registered command to the slave
//   i_vrb_rsp_*                  slave response (valid/err/rdata)
//   o_busy                       transaction in flight
//   o_owner                      current/last owner (0=LSU, 1=IFU)
//
// A grant happens in an IDLE cycle; the slave may answer in the very first
// BUSY cycle. The response is passed straight through to the owner, and the
// FSM always returns to IDLE for at least one cycle afterwards. If TIMEOUT is
// nonzero, a BUSY phase that reaches TIMEOUT silent cycles is closed with an
// error response.
module vrb_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            i_lsu_vrb_cmd_valid,
    input  logic [AW-1:0]   i_lsu_vrb_cmd_addr,
    input  logic            i_lsu_vrb_cmd_read,
    input  logic [DW-1:0]   i_lsu_vrb_cmd_wdata,
    input  logic [DW/8-1:0] i_lsu_vrb_cmd_wmask,
    output logic            o_lsu_vrb_rsp_valid,
    output logic            o_lsu_vrb_rsp_err,
    output logic [DW-1:0]   o_lsu_vrb_rsp_rdata,

    input  logic            i_ifu_vrb_cmd_valid,
    input  logic [AW-1:0]   i_ifu_vrb_cmd_addr,
    input  logic            i_ifu_vrb_cmd_read,
    input  logic [DW-1:0]   i_ifu_vrb_cmd_wdata,
    input  logic [DW/8-1:0] i_ifu_vrb_cmd_wmask,
    output logic            o_ifu_vrb_rsp_valid,
    output logic            o_ifu_vrb_rsp_err,
    output logic [DW-1:0]   o_ifu_vrb_rsp_rdata,

    output logic            o_vrb_cmd_valid,
    output logic [AW-1:0]   o_vrb_cmd_addr,
    output logic            o_vrb_cmd_read,
    output logic [DW-1:0]   o_vrb_cmd_wdata,
    output logic [DW/8-1:0] o_vrb_cmd_wmask,
    input  logic            i_vrb_rsp_valid,
    input  logic            i_vrb_rsp_err,
    input  logic [DW-1:0]   i_vrb_rsp_rdata,

    output logic            o_busy,
    output logic            o_owner
);

    localparam int MW = DW / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic           owner;
    logic           last_grant;     // 0=LSU, 1=IFU
    logic [AW-1:0]  cmd_addr;
    logic           cmd_read;
    logic [DW-1:0]  cmd_wdata;
    logic [MW-1:0]  cmd_wmask;
    logic [CW-1:0]  cnt;

    logic           any_req;
    logic           grant_ifu;
    logic           timeout_hit;
    logic           slave_done;
    logic           rsp_valid;
    logic           rsp_err;
    logic [DW-1:0]  rsp_rdata;

    assign any_req   = i_lsu_vrb_cmd_valid | i_ifu_vrb_cmd_valid;
    // IFU wins when alone, or on a tie when LSU held the previous grant.
    assign grant_ifu = i_ifu_vrb_cmd_valid & (~i_lsu_vrb_cmd_valid | ~last_grant);

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));
    assign o_owner     = owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        o_busy              = 1'b0;
        o_vrb_cmd_valid     = 1'b0;
        o_vrb_cmd_addr      = '0;
        o_vrb_cmd_read      = 1'b0;
        o_vrb_cmd_wdata     = '0;
        o_vrb_cmd_wmask     = '0;
        slave_done          = 1'b0;
        rsp_valid           = 1'b0;
        rsp_err             = 1'b0;
        rsp_rdata           = '0;
        o_lsu_vrb_rsp_valid = 1'b0;
        o_lsu_vrb_rsp_err   = 1'b0;
        o_lsu_vrb_rsp_rdata = '0;
        o_ifu_vrb_rsp_valid = 1'b0;
        o_ifu_vrb_rsp_err   = 1'b0;
        o_ifu_vrb_rsp_rdata = '0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                o_busy          = 1'b1;
                o_vrb_cmd_valid = 1'b1;
                o_vrb_cmd_addr  = cmd_addr;
                o_vrb_cmd_read  = cmd_read;
                o_vrb_cmd_wdata = cmd_wdata;
                o_vrb_cmd_wmask = cmd_wmask;

                // A real slave answer takes priority over a coincident timeout.
                slave_done = i_vrb_rsp_valid;
                rsp_valid  = i_vrb_rsp_valid | timeout_hit;
                rsp_err    = slave_done ? i_vrb_rsp_err   : 1'b1;
                rsp_rdata  = slave_done ? i_vrb_rsp_rdata : '0;

                if (rsp_valid) begin
                    state_nxt = IDLE;
                    if (owner) begin
                        o_ifu_vrb_rsp_valid = 1'b1;
                        o_ifu_vrb_rsp_err   = rsp_err;
                        o_ifu_vrb_rsp_rdata = rsp_rdata;
                    end else begin
                        o_lsu_vrb_rsp_valid = 1'b1;
                        o_lsu_vrb_rsp_err   = rsp_err;
                        o_lsu_vrb_rsp_rdata = rsp_rdata;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cmd_addr   <= '0;
            cmd_read   <= 1'b0;
            cmd_wdata  <= '0;
            cmd_wmask  <= '0;
            cnt        <= '0;
        end else if (state == IDLE) begin
            if (any_req) begin
                owner      <= grant_ifu;
                last_grant <= grant_ifu;
                cmd_addr   <= grant_ifu ? i_ifu_vrb_cmd_addr  : i_lsu_vrb_cmd_addr;
                cmd_read   <= grant_ifu ? i_ifu_vrb_cmd_read  : i_lsu_vrb_cmd_read;
                cmd_wdata  <= grant_ifu ? i_ifu_vrb_cmd_wdata : i_lsu_vrb_cmd_wdata;
                cmd_wmask  <= grant_ifu ? i_ifu_vrb_cmd_wmask : i_lsu_vrb_cmd_wmask;
                cnt        <= '0;
            end
        end else if (!i_vrb_rsp_valid && !timeout_hit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vrb_arb.sv
module tb_vrb_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            lsu_valid, lsu_read, ifu_valid, ifu_read;
    logic [AW-1:0]   lsu_addr, ifu_addr;
    logic [DW-1:0]   lsu_wdata, ifu_wdata;
    logic [MW-1:0]   lsu_wmask, ifu_wmask;
    logic            lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid, ifu_rsp_err;
    logic [DW-1:0]   lsu_rsp_rdata, ifu_rsp_rdata;
    logic            cmd_valid, cmd_read;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [MW-1:0]   cmd_wmask;
    logic            s_rsp_valid, s_rsp_err;
    logic [DW-1:0]   s_rsp_rdata;
    logic            busy, owner;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    vrb_arb #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_lsu_vrb_cmd_valid (lsu_valid),
        .i_lsu_vrb_cmd_addr  (lsu_addr),
        .i_lsu_vrb_cmd_read  (lsu_read),
        .i_lsu_vrb_cmd_wdata (lsu_wdata),
        .i_lsu_vrb_cmd_wmask (lsu_wmask),
        .o_lsu_vrb_rsp_valid (lsu_rsp_valid),
        .o_lsu_vrb_rsp_err   (lsu_rsp_err),
        .o_lsu_vrb_rsp_rdata (lsu_rsp_rdata),
        .i_ifu_vrb_cmd_valid (ifu_valid),
        .i_ifu_vrb_cmd_addr  (ifu_addr),
        .i_ifu_vrb_cmd_read  (ifu_read),
        .i_ifu_vrb_cmd_wdata (ifu_wdata),
        .i_ifu_vrb_cmd_wmask (ifu_wmask),
        .o_ifu_vrb_rsp_valid (ifu_rsp_valid),
        .o_ifu_vrb_rsp_err   (ifu_rsp_err),
        .o_ifu_vrb_rsp_rdata (ifu_rsp_rdata),
        .o_vrb_cmd_valid     (cmd_valid),
        .o_vrb_cmd_addr      (cmd_addr),
        .o_vrb_cmd_read      (cmd_read),
        .o_vrb_cmd_wdata     (cmd_wdata),
        .o_vrb_cmd_wmask     (cmd_wmask),
        .i_vrb_rsp_valid     (s_rsp_valid),
        .i_vrb_rsp_err       (s_rsp_err),
        .i_vrb_rsp_rdata     (s_rsp_rdata),
        .o_busy              (busy),
        .o_owner             (owner)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " lsu_rsp_valid"}, lsu_rsp_valid, 0);
        chk({tag, " ifu_rsp_valid"}, ifu_rsp_valid, 0);
        chk({tag, " lsu_rsp_rdata"}, lsu_rsp_rdata, 0);
        chk({tag, " ifu_rsp_err"},   ifu_rsp_err,   0);
    endtask

    logic exp_own;
    logic [31:0] exp_addr;

    initial begin
        rst_n = 1'b0;
        lsu_valid = 0; lsu_read = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        ifu_valid = 0; ifu_read = 0; ifu_addr = '0; ifu_wdata = '0; ifu_wmask = '0;
        s_rsp_valid = 0; s_rsp_err = 0; s_rsp_rdata = '0;

        // Reset state
        #3;
        chk("rst busy", busy, 0);
        chk("rst cmd_valid", cmd_valid, 0);
        chk("rst owner", owner, 0);
        chk_quiet("rst");
        #4 rst_n = 1'b1;
        cyc();

        // LSU-only read, slave answers in the first BUSY cycle
        lsu_valid = 1; lsu_read = 1; lsu_addr = 32'h100;
        #1;
        chk("t1 idle busy", busy, 0);
        chk("t1 idle cmd_valid", cmd_valid, 0);
        cyc();
        chk("t1 busy", busy, 1);
        chk("t1 cmd_valid", cmd_valid, 1);
        chk("t1 cmd_addr", cmd_addr, 32'h100);
        chk("t1 cmd_read", cmd_read, 1);
        chk("t1 owner", owner, 0);
        s_rsp_valid = 1; s_rsp_rdata = 32'hDEADBEEF;
        #1;
        chk("t1 lsu_rsp_valid", lsu_rsp_valid, 1);
        chk("t1 lsu_rsp_rdata", lsu_rsp_rdata, 32'hDEADBEEF);
        chk("t1 lsu_rsp_err", lsu_rsp_err, 0);
        chk("t1 ifu_rsp_valid", ifu_rsp_valid, 0);
        chk("t1 ifu_rsp_rdata", ifu_rsp_rdata, 0);
        lsu_valid = 0;
        cyc();
        s_rsp_valid = 0; s_rsp_rdata = '0;
        #1;
        chk("t1 after busy", busy, 0);
        chk("t1 after cmd_addr", cmd_addr, 0);
        chk_quiet("t1 after");

        // Both request continuously: LSU was last, so IFU, LSU, IFU, LSU
        lsu_valid = 1; lsu_read = 1; lsu_addr = 32'h10;
        ifu_valid = 1; ifu_read = 0; ifu_addr = 32'h20;
        ifu_wdata = 32'hA5A5_5A5A; ifu_wmask = 4'hF;
        for (int k = 0; k < 4; k++) begin
            exp_own  = (k % 2 == 0);
            exp_addr = exp_own ? 32'h20 : 32'h10;
            cyc();
            chk("rr busy", busy, 1);
            chk("rr owner", owner, exp_own);
            chk("rr cmd_addr", cmd_addr, exp_addr);
            chk("rr cmd_read", cmd_read, !exp_own);
            if (exp_own) begin
                chk("rr cmd_wdata", cmd_wdata, 32'hA5A5_5A5A);
                chk("rr cmd_wmask", cmd_wmask, 4'hF);
            end
            s_rsp_valid = 1; s_rsp_rdata = 32'h1000 + k;
            #1;
            chk("rr lsu_rsp_valid", lsu_rsp_valid, !exp_own);
            chk("rr ifu_rsp_valid", ifu_rsp_valid, exp_own);
            chk("rr owner rdata", exp_own ? ifu_rsp_rdata : lsu_rsp_rdata, 32'h1000 + k);
            chk("rr other rdata", exp_own ? lsu_rsp_rdata : ifu_rsp_rdata, 0);
            cyc();
            s_rsp_valid = 0; s_rsp_rdata = '0;
            #1;
            chk("rr bubble busy", busy, 0);
            chk("rr bubble cmd_valid", cmd_valid, 0);
        end

        // IFU command is held stable while the master changes its inputs
        lsu_valid = 0; ifu_addr = 32'h40; ifu_read = 1;
        cyc();
        chk("hold owner", owner, 1);
        chk("hold addr0", cmd_addr, 32'h40);
        ifu_addr = 32'h44; ifu_read = 0;
        #1;
        chk("hold addr1", cmd_addr, 32'h40);
        chk("hold read1", cmd_read, 1);
        ifu_valid = 0;
        cyc();
        chk("hold addr2", cmd_addr, 32'h40);
        chk("hold busy2", busy, 1);
        chk_quiet("hold wait");
        cyc();
        s_rsp_valid = 1; s_rsp_rdata = 32'h1234;
        #1;
        chk("hold ifu_rsp_valid", ifu_rsp_valid, 1);
        chk("hold ifu_rsp_rdata", ifu_rsp_rdata, 32'h1234);
        cyc();
        s_rsp_valid = 0; s_rsp_rdata = '0;
        #1;
        chk("hold after busy", busy, 0);

        // Silent slave: timeout strobe when the counter reaches 4
        lsu_valid = 1; lsu_read = 0; lsu_addr = 32'h200;
        cyc();
        chk("to busy1", busy, 1);
        chk_quiet("to c1");
        for (int k = 2; k <= 4; k++) begin
            cyc();
            chk("to busy", busy, 1);
            chk_quiet("to wait");
        end
        cyc();
        chk("to lsu_rsp_valid", lsu_rsp_valid, 1);
        chk("to lsu_rsp_err", lsu_rsp_err, 1);
        chk("to lsu_rsp_rdata", lsu_rsp_rdata, 0);
        chk("to ifu_rsp_valid", ifu_rsp_valid, 0);
        lsu_valid = 0;
        cyc();
        chk("to after busy", busy, 0);
        chk_quiet("to after");

        // Slave answer coinciding with the timeout cycle wins
        ifu_valid = 1; ifu_addr = 32'h300;
        for (int k = 1; k <= 4; k++) cyc();
        chk("race busy4", busy, 1);
        chk_quiet("race c4");
        cyc();
        s_rsp_valid = 1; s_rsp_err = 0; s_rsp_rdata = 32'h55;
        #1;
        chk("race ifu_rsp_valid", ifu_rsp_valid, 1);
        chk("race ifu_rsp_err", ifu_rsp_err, 0);
        chk("race ifu_rsp_rdata", ifu_rsp_rdata, 32'h55);
        ifu_valid = 0;
        cyc();
        s_rsp_valid = 0; s_rsp_rdata = '0;
        #1;
        chk("race after busy", busy, 0);

        // Stray slave response in IDLE is ignored
        s_rsp_valid = 1; s_rsp_err = 1; s_rsp_rdata = 32'hFF;
        #1;
        chk_quiet("stray");
        chk("stray ifu_rsp_rdata", ifu_rsp_rdata, 0);
        chk("stray lsu_rsp_err", lsu_rsp_err, 0);
        s_rsp_valid = 0; s_rsp_err = 0; s_rsp_rdata = '0;

        // Reset in the middle of an LSU transaction
        lsu_valid = 1; lsu_addr = 32'h400;
        cyc();
        chk("mid busy", busy, 1);
        chk("mid owner", owner, 0);
        #1;
        rst_n = 0;
        s_rsp_valid = 1; s_rsp_rdata = 32'h77;
        #1;
        chk("mid rst busy", busy, 0);
        chk("mid rst cmd_valid", cmd_valid, 0);
        chk("mid rst cmd_addr", cmd_addr, 0);
        chk("mid rst owner", owner, 0);
        chk_quiet("mid rst");
        #2;
        rst_n = 1;
        s_rsp_valid = 0; s_rsp_rdata = '0;
        lsu_addr = 32'h500; ifu_addr = 32'h600;
        ifu_valid = 1;

        // Tie after reset: LSU first, then IFU
        cyc();
        chk("post owner0", owner, 0);
        chk("post addr0", cmd_addr, 32'h500);
        s_rsp_valid = 1; s_rsp_rdata = 32'hA;
        #1;
        chk("post lsu_rsp_valid", lsu_rsp_valid, 1);
        cyc();
        s_rsp_valid = 0;
        #1;
        chk("post bubble busy", busy, 0);
        cyc();
        chk("post owner1", owner, 1);
        chk("post addr1", cmd_addr, 32'h600);
        lsu_valid = 0; ifu_valid = 0;
        s_rsp_valid = 1; s_rsp_rdata = 32'hB;
        #1;
        chk("post ifu_rsp_valid", ifu_rsp_valid, 1);
        chk("post ifu_rsp_rdata", ifu_rsp_rdata, 32'hB);
        cyc();
        s_rsp_valid = 0; s_rsp_rdata = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vrb_arb.md
VRB_ARB -- requirements
Module: vrb_arb

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width; DW/8 mask bits.
REQ-003 Parameter TIMEOUT, default 255, cycles allowed in BUSY without a slave response; 0 disables the timeout.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_lsu_vrb_cmd_valid / i_ifu_vrb_cmd_valid  in  1 each  master request, held high until its response.
REQ-007 i_lsu_vrb_cmd_addr / i_ifu_vrb_cmd_addr  in  AW each  request address.
REQ-008 i_lsu_vrb_cmd_read / i_ifu_vrb_cmd_read  in  1 each  1=read, 0=write.
REQ-009 i_lsu_vrb_cmd_wdata / i_ifu_vrb_cmd_wdata  in  DW each; i_lsu_vrb_cmd_wmask / i_ifu_vrb_cmd_wmask  in  DW/8 each.
REQ-010 o_lsu_vrb_rsp_valid / o_ifu_vrb_rsp_valid  out  1 each  response strobe to that master.
REQ-011 o_lsu_vrb_rsp_err / o_ifu_vrb_rsp_err  out  1 each; o_lsu_vrb_rsp_rdata / o_ifu_vrb_rsp_rdata  out  DW each.
REQ-012 o_vrb_cmd_valid, o_vrb_cmd_addr[AW], o_vrb_cmd_read, o_vrb_cmd_wdata[DW], o_vrb_cmd_wmask[DW/8]  out  command to shared slave.
REQ-013 i_vrb_rsp_valid, i_vrb_rsp_err, i_vrb_rsp_rdata[DW]  in  slave response.
REQ-014 o_busy  out  1  high in BUSY; o_owner  out  1  current/last owner (0=LSU, 1=IFU).

Function
REQ-015 FSM states SHALL be IDLE and BUSY; one outstanding transaction maximum.
REQ-016 IDLE with any request SHALL grant one master, register its addr/read/wdata/wmask and owner, and enter BUSY next cycle.
REQ-017 Arbitration SHALL be round-robin: on simultaneous requests, the master not granted last wins; single requester wins unconditionally.
REQ-018 In BUSY, o_vrb_cmd_valid SHALL be 1 and all o_vrb_cmd_* SHALL come from the registered command, unaffected by later master input changes.
REQ-019 In IDLE, o_vrb_cmd_valid SHALL be 0 and o_vrb_cmd_* SHALL be 0.
REQ-020 In BUSY, i_vrb_rsp_valid SHALL be forwarded combinationally in the same cycle to the owner's rsp_valid/err/rdata; the non-owner sees rsp_valid=0.
REQ-021 The cycle after a response, state SHALL be IDLE (one bubble cycle); that response cycle's requests SHALL NOT be arbitrated.
REQ-022 i_vrb_rsp_valid in IDLE SHALL be ignored (no master strobe).
REQ-023 Non-strobed master rsp_err and rsp_rdata SHALL be 0.
REQ-024 Timeout counter SHALL clear on grant and increment each BUSY cycle without i_vrb_rsp_valid; on reaching TIMEOUT, owner gets rsp_valid=1, err=1, rdata=0 that cycle, then IDLE.
REQ-025 Slave response and timeout in the same cycle: the slave response SHALL win.
REQ-026 Owner dropping cmd_valid during BUSY SHALL NOT abort; the transaction completes and the response is still delivered.
REQ-027 Minimum request-to-response latency SHALL be 1 cycle (grant cycle N, slave may answer in N+1).

Reset
REQ-028 On rst_n low, state SHALL be IDLE immediately; counter 0; command regs 0; last-grant pointer = IFU (so LSU wins the first tie); o_owner=0.
REQ-029 During reset all outputs SHALL be 0; reset mid-BUSY SHALL discard the transaction with no response strobe.

Verification
REQ-030 LSU-only read addr 0x100, slave answers rdata 0xDEADBEEF in N+1 -> LSU rsp_valid in N+1 with that data, IFU sees none, IDLE at N+2.
REQ-031 Both request continuously from reset -> grants alternate LSU, IFU, LSU, IFU; each transaction 2 cycles plus bubble.
REQ-032 IFU granted addr 0x40, IFU changes addr to 0x44 during BUSY -> o_vrb_cmd_addr stays 0x40 until response.
REQ-033 TIMEOUT=4, slave silent -> after 4 BUSY cycles owner sees rsp_valid=1, err=1, rdata=0; next cycle IDLE.
REQ-034 Stray i_vrb_rsp_valid in IDLE, then rst_n pulsed low mid-BUSY -> no master strobe either time; all outputs 0 during reset; LSU wins next tie.
